// File: rtl/sr_fetch_queue.sv
// Instruction fetch front-end: credit-limited word reads, in-order responses, PC/word queue, redirect flush.
// Define SR_FETCH_BYPASS_EN to forward a response to the core in the same cycle when the queue is empty.
module sr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 30,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr_data,
    output logic [31:0]       instr_pc
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];

    logic             head_valid_c;
    logic             req_valid_c;
    logic             req_hs_c;
    logic             rsp_dec_c;
    logic             rsp_run_c;
    logic             bypass_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] out_after_c;
    logic [31:0]      redirect_pc_al_c;
    logic             unused_c;

    // Credit rule: in-flight plus buffered never exceeds the queue size.
    assign req_valid_c  = (state_q == ST_RUN) &&
                          ((SUM_W'(outstanding_q) + SUM_W'(count_q)) < SUM_W'(DEPTH));
    assign req_hs_c     = req_valid_c && mem_req_ready;
    assign rsp_dec_c    = mem_rsp_valid && (state_q != ST_IDLE);
    assign rsp_run_c    = mem_rsp_valid && (state_q == ST_RUN);
    assign head_valid_c = (count_q != '0);
    assign out_after_c  = outstanding_q + CNT_W'(req_hs_c) - CNT_W'(rsp_dec_c);
    assign redirect_pc_al_c = {redirect_pc[31:2], 2'b00};

`ifdef SR_FETCH_BYPASS_EN
    assign bypass_c = !head_valid_c && (state_q == ST_RUN) && !redirect && mem_rsp_valid;
`else
    assign bypass_c = 1'b0;
`endif

    // A bypassed word consumed this cycle never enters the queue.
    assign push_c = rsp_run_c && !redirect && !(bypass_c && instr_ready);
    assign pop_c  = head_valid_c && instr_ready && !redirect;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = out_after_c;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        data_d        = data_q;
        pc_d          = pc_q;

        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect && (out_after_c != '0)) begin
                    state_d    = ST_DRAIN;
                    drop_cnt_d = out_after_c;
                end
            end
            ST_DRAIN: begin
                drop_cnt_d = drop_cnt_q - CNT_W'(mem_rsp_valid);
                if (drop_cnt_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (req_hs_c) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (rsp_run_c && !redirect) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
        end
        if (push_c) begin
            data_d[wr_ptr_q] = mem_rsp_data;
            pc_d[wr_ptr_q]   = rsp_pc_q;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        // Redirect overrides every same-cycle queue and PC update.
        if (redirect) begin
            fetch_pc_d = redirect_pc_al_c;
            rsp_pc_d   = redirect_pc_al_c;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC_AL;
            rsp_pc_q      <= RESET_PC_AL;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            data_q        <= '{default: '0};
            pc_q          <= '{default: '0};
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            data_q        <= data_d;
            pc_q          <= pc_d;
        end
    end

    assign mem_req_valid = req_valid_c;
    assign mem_req_addr  = fetch_pc_q[ADDR_W+1:2];
    assign instr_valid   = head_valid_c || bypass_c;
    assign instr_data    = head_valid_c ? data_q[rd_ptr_q] : (bypass_c ? mem_rsp_data : 32'h0);
    assign instr_pc      = head_valid_c ? pc_q[rd_ptr_q]   : (bypass_c ? rsp_pc_q     : 32'h0);

    assign unused_c = ^{redirect_pc[1:0], fetch_pc_q};
endmodule

// File: tb/tb_sr_fetch_queue.sv
// Scoreboard bench for sr_fetch_queue: behavioural variable-latency memory, expected-word queue, pop monitor.
module tb_sr_fetch_queue;
    localparam int unsigned ADDR_W = 30;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr_data;
    logic [31:0]       instr_pc;

    int                total = 0;
    int                bad   = 0;
    int                n_pop = 0;
    int                n_acc = 0;
    int                lat   = 1;
    int                mcyc  = 0;
    int                snap  = 0;
    logic [31:0]       data_xor = 32'h0;
    exp_t              exp_q[$];
    exp_t              mon_e;
    logic [ADDR_W-1:0] pend_a[$];
    int                pend_due[$];
    logic              hs;
    logic [ADDR_W-1:0] hs_addr;

    always #5 clk = ~clk;

    sr_fetch_queue #(.DEPTH(4), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = start + 32'(4 * i);
            e.data = {2'b00, e.pc[31:2]} ^ data_xor;
            exp_q.push_back(e);
        end
    endtask

    task automatic to_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic to_pos();
        @(posedge clk);
        #2;
    endtask

    task automatic hold_reset(input int l, input logic mrdy, input logic irdy);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        exp_q.delete();
        lat           = l;
        mem_req_ready = mrdy;
        instr_ready   = irdy;
        redirect      = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Memory model: word = address ^ data_xor, in order, lat cycles from acceptance to consumption.
    initial begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            hs      = mem_req_valid && mem_req_ready;
            hs_addr = mem_req_addr;
            @(posedge clk);
            #1;
            mcyc++;
            if (rst) begin
                pend_a.delete();
                pend_due.delete();
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = 32'h0;
            end else begin
                if (mem_rsp_valid && pend_a.size() > 0) begin
                    pend_a.delete(0);
                    pend_due.delete(0);
                end
                if (hs) begin
                    pend_a.push_back(hs_addr);
                    pend_due.push_back(mcyc + lat - 1);
                    n_acc++;
                end
                if (pend_a.size() > 0 && pend_due[0] <= mcyc) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = {2'b00, pend_a[0]} ^ data_xor;
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = 32'h0;
                end
            end
        end
    end

    // Monitor: every consumed word must match the scoreboard head; idle outputs must read zero.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (instr_valid && instr_ready && !redirect) begin
                    n_pop++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL pop_unexpected: got pc %h data %h, nothing expected", instr_pc, instr_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("instr_pc", instr_pc, mon_e.pc);
                        check("instr_data", instr_data, mon_e.data);
                    end
                end else if (!instr_valid) begin
                    check("idle_data", instr_data, 32'h0);
                    check("idle_pc", instr_pc, 32'h0);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        mem_req_ready = 1'b1;
        instr_ready   = 1'b1;

        // Reset values, first request timing, sustained throughput
        hold_reset(1, 1'b1, 1'b1);
        to_neg(1);
        check("rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_req_addr", 32'(mem_req_addr), 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_instr_data", instr_data, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        expect_seq(32'h0, 40);
        release_reset();
        to_neg(1);
        check("t1_c1_req_valid", 32'(mem_req_valid), 32'h0);
        to_neg(1);
        check("t1_c2_req_valid", 32'(mem_req_valid), 32'h1);
        check("t1_c2_req_addr", 32'(mem_req_addr), 32'h0);
        to_neg(4);
        snap = n_pop;
        to_neg(10);
        check("t1_throughput", 32'(n_pop - snap), 32'd10);

        // Core stalled: four credits used, then drain and resume at PC 16
        hold_reset(1, 1'b1, 1'b0);
        expect_seq(32'h0, 40);
        release_reset();
        snap = n_acc;
        to_neg(11);
        check("t2_accepted", 32'(n_acc - snap), 32'd4);
        check("t2_req_valid_full", 32'(mem_req_valid), 32'h0);
        check("t2_head_valid", 32'(instr_valid), 32'h1);
        check("t2_head_pc", instr_pc, 32'h0);
        snap = n_pop;
        to_pos();
        instr_ready = 1'b1;
        to_neg(1);
        check("t2_req_still_full", 32'(mem_req_valid), 32'h0);
        to_neg(1);
        check("t2_resume_valid", 32'(mem_req_valid), 32'h1);
        check("t2_resume_addr", 32'(mem_req_addr), 32'd4);
        to_neg(8);
        check("t2_drain_pops", 32'(n_pop - snap), 32'd10);

        // Redirect with two requests in flight on a 3-cycle memory
        hold_reset(3, 1'b0, 1'b1);
        release_reset();
        to_pos();
        mem_req_ready = 1'b1;
        to_neg(1);
        check("t3_req0_addr", 32'(mem_req_addr), 32'h0);
        to_neg(1);
        check("t3_req1_addr", 32'(mem_req_addr), 32'h1);
        to_pos();
        mem_req_ready = 1'b0;
        redirect      = 1'b1;
        redirect_pc   = 32'h100;
        to_neg(1);
        check("t3_pre_req_valid", 32'(mem_req_valid), 32'h1);
        check("t3_pre_rsp_valid", 32'(mem_rsp_valid), 32'h0);
        to_pos();
        redirect      = 1'b0;
        mem_req_ready = 1'b1;
        expect_seq(32'h100, 40);
        to_neg(1);
        check("t3_drain_req_valid0", 32'(mem_req_valid), 32'h0);
        check("t3_drain_instr_valid0", 32'(instr_valid), 32'h0);
        check("t3_drain_rsp_seen", 32'(mem_rsp_valid), 32'h1);
        to_neg(1);
        check("t3_drain_req_valid1", 32'(mem_req_valid), 32'h0);
        check("t3_drain_instr_valid1", 32'(instr_valid), 32'h0);
        to_neg(1);
        check("t3_new_req_valid", 32'(mem_req_valid), 32'h1);
        check("t3_new_req_addr", 32'(mem_req_addr), 32'h40);
        snap = n_pop;
        to_neg(14);
        check("t3_progress", 32'(n_pop > snap), 32'h1);

        // Redirect coinciding with a request handshake, a response and a pop
        hold_reset(1, 1'b1, 1'b1);
        expect_seq(32'h0, 40);
        release_reset();
        to_neg(7);
        to_pos();
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        to_neg(1);
        check("t4_coinc_req", 32'(mem_req_valid), 32'h1);
        check("t4_coinc_pop", 32'(instr_valid), 32'h1);
        check("t4_coinc_rsp", 32'(mem_rsp_valid), 32'h1);
        to_pos();
        redirect = 1'b0;
        check("t4_pops_before", 32'(exp_q.size()), 32'd36);
        exp_q.delete();
        expect_seq(32'h100, 40);
        to_neg(1);
        check("t4_flush_instr_valid", 32'(instr_valid), 32'h0);
        check("t4_drain_req_valid", 32'(mem_req_valid), 32'h0);
        to_neg(1);
        check("t4_new_req_valid", 32'(mem_req_valid), 32'h1);
        check("t4_new_req_addr", 32'(mem_req_addr), 32'h40);
        check("t4_still_empty", 32'(instr_valid), 32'h0);
        snap = n_pop;
        to_neg(6);
        check("t4_new_pops", 32'(n_pop - snap), 32'd5);

        // Reset asserted with three words queued
        hold_reset(1, 1'b1, 1'b0);
        expect_seq(32'h0, 40);
        release_reset();
        to_neg(6);
        check("t5_pre_valid", 32'(instr_valid), 32'h1);
        check("t5_pre_req_valid", 32'(mem_req_valid), 32'h0);
        rst = 1'b1;
        #1;
        check("t5_rst_instr_valid", 32'(instr_valid), 32'h0);
        check("t5_rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("t5_rst_instr_pc", instr_pc, 32'h0);
        check("t5_rst_req_addr", 32'(mem_req_addr), 32'h0);
        hold_reset(1, 1'b1, 1'b1);
        expect_seq(32'h0, 40);
        release_reset();
        to_neg(2);
        check("t5_restart_valid", 32'(mem_req_valid), 32'h1);
        check("t5_restart_addr", 32'(mem_req_addr), 32'h0);
        snap = n_pop;
        to_neg(6);
        check("t5_restart_pops", 32'(n_pop - snap), 32'd5);

        // Response-to-instr_valid latency on an empty queue
        data_xor = 32'hDEADBEEF;
        hold_reset(1, 1'b1, 1'b0);
        expect_seq(32'h0, 40);
        release_reset();
        to_neg(3);
        check("t6_rsp_valid", 32'(mem_rsp_valid), 32'h1);
        check("t6_rsp_data", mem_rsp_data, 32'hDEADBEEF);
`ifdef SR_FETCH_BYPASS_EN
        check("t6_bypass_valid", 32'(instr_valid), 32'h1);
        check("t6_bypass_data", instr_data, 32'hDEADBEEF);
        check("t6_bypass_pc", instr_pc, 32'h0);
`else
        check("t6_nobypass_valid", 32'(instr_valid), 32'h0);
`endif
        to_neg(1);
        check("t6_queued_valid", 32'(instr_valid), 32'h1);
        check("t6_queued_data", instr_data, 32'hDEADBEEF);
        check("t6_queued_pc", instr_pc, 32'h0);
        snap = n_pop;
        to_pos();
        instr_ready = 1'b1;
        to_neg(10);
        check("t6_stream", 32'(n_pop > snap), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
